// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the ALU scheduler: opcodes, FSM states, flag positions.
package alu_sched_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_DIV = 4'd4,
    OP_MOD = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_XOR = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_ERR   = 2;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic needs_divisor(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the caller owns the last_grant register.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto one external combinational ALU, holds its inputs for a
// settle window, then returns the registered result with flags over valid/ready.
module alu_scheduler #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic [2:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_btn,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout
);
  import alu_sched_pkg::*;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state;
  logic             last_grant;
  logic             owner;
  logic [3:0]       op_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       grant;
  logic             hs;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;
  logic             sel_bad;
  logic [WIDTH-1:0] cap_s;
  logic             cap_carry;
  logic             cap_zero;

  // Gated by rst so a request presented during reset never sees a handshake.
  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     ((state == IDLE) && !rst),
    .grant      (grant)
  );

  always_comb begin
    req_ready = grant;
    hs        = |grant;
    sel_a     = grant[1] ? req1_a  : req0_a;
    sel_b     = grant[1] ? req1_b  : req0_b;
    sel_op    = grant[1] ? req1_op : req0_op;
    sel_bad   = !is_legal_op(sel_op) || (needs_divisor(sel_op) && (sel_b == '0));
    cap_s     = err_q ? '0 : alu_s;
    cap_carry = !err_q && ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_cout;
    // An error response reports only the err flag, never zero.
    cap_zero  = !err_q && (cap_s == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 2'b00;
      rsp_s      <= '0;
      rsp_flags  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_btn    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_btn    <= sel_bad ? 4'b0000 : sel_op;
            op_q       <= sel_op;
            err_q      <= sel_bad;
            owner      <= grant[1];
            last_grant <= grant[1];
            cnt        <= CNT_INIT;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_s                <= cap_s;
            rsp_flags[FLAG_ZERO]  <= cap_zero;
            rsp_flags[FLAG_CARRY] <= cap_carry;
            rsp_flags[FLAG_ERR]   <= err_q;
            rsp_valid            <= owner ? 2'b10 : 2'b01;
            alu_btn              <= 4'b0000;
            state                <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: behavioural ALU beside two scheduler instances
// (settle window 1 and 3), hand-computed expectations.
module tb_alu_scheduler;

  logic clk;
  logic rst;

  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
  logic [3:0] rsp_s, alu_a, alu_b, alu_btn, alu_s;
  logic [2:0] rsp_flags;
  logic       alu_cout;

  logic [1:0] req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [3:0] req0_a3, req0_b3, req0_op3, req1_a3, req1_b3, req1_op3;
  logic [3:0] rsp_s3, alu_a3, alu_b3, alu_btn3, alu_s3;
  logic [2:0] rsp_flags3;
  logic       alu_cout3;

  int checks = 0;
  int errors = 0;

  alu_scheduler #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_btn(alu_btn),
    .alu_s(alu_s), .alu_cout(alu_cout)
  );

  alu_scheduler #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req0_a(req0_a3), .req0_b(req0_b3), .req0_op(req0_op3),
    .req1_a(req1_a3), .req1_b(req1_b3), .req1_op(req1_op3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_s(rsp_s3), .rsp_flags(rsp_flags3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_btn(alu_btn3),
    .alu_s(alu_s3), .alu_cout(alu_cout3)
  );

  // Behavioural ALU: returns {cout, s}; SUB is B-A with cout as borrow.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] btn);
    logic [4:0] r;
    logic [3:0] t;
    r = '0;
    case (btn)
      4'd1: r = {1'b0, a} + {1'b0, b};
      4'd2: begin t = b - a; r = {a > b, t}; end
      4'd3: begin t = a * b; r = {1'b0, t}; end
      4'd4: begin t = (b != 0) ? a / b : 4'd0; r = {1'b0, t}; end
      4'd5: begin t = (b != 0) ? a % b : 4'd0; r = {1'b0, t}; end
      4'd6: r = {1'b0, a & b};
      4'd7: r = {1'b0, a | b};
      4'd8: r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    {alu_cout, alu_s}   = alu_fn(alu_a, alu_b, alu_btn);
    {alu_cout3, alu_s3} = alu_fn(alu_a3, alu_b3, alu_btn3);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One single-requester transaction on the SETTLE_CYCLES=1 instance, ready taken at once.
  task automatic serve(input int who, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [3:0] exp_btn,
                       input logic [3:0] exp_s, input logic [2:0] exp_flags);
    logic [1:0] oh;
    oh = (who == 1) ? 2'b10 : 2'b01;
    if (who == 1) begin
      req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_a = a; req0_b = b; req0_op = op;
    end
    req_valid = oh;
    #1;
    chk("serve_ready", 8'(req_ready), 8'(oh));
    step;
    req_valid = 2'b00;
    chk("serve_exec_btn", 8'(alu_btn), 8'(exp_btn));
    chk("serve_exec_a", 8'(alu_a), 8'(a));
    chk("serve_exec_nornd", 8'(rsp_valid), 8'd0);
    step;
    chk("serve_rsp_valid", 8'(rsp_valid), 8'(oh));
    chk("serve_rsp_s", 8'(rsp_s), 8'(exp_s));
    chk("serve_rsp_flags", 8'(rsp_flags), 8'(exp_flags));
    chk("serve_rsp_btn", 8'(alu_btn), 8'd0);
    rsp_ready = oh;
    step;
    rsp_ready = 2'b00;
    chk("serve_done_valid", 8'(rsp_valid), 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    req_valid3 = '0; rsp_ready3 = '0;
    req0_a3 = '0; req0_b3 = '0; req0_op3 = '0; req1_a3 = '0; req1_b3 = '0; req1_op3 = '0;

    step;
    step;
    chk("rst_req_ready", 8'(req_ready), 8'd0);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_rsp_s", 8'(rsp_s), 8'd0);
    chk("rst_rsp_flags", 8'(rsp_flags), 8'd0);
    chk("rst_alu_btn", 8'(alu_btn), 8'd0);
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    rst = 1'b0;
    step;

    // Req1 ADD 15+1 with owner's rsp_ready withheld; non-owner ready must be ignored.
    req1_a = 4'd15; req1_b = 4'd1; req1_op = 4'd1;
    req_valid = 2'b10;
    #1;
    chk("t2_ready", 8'(req_ready), 8'b10);
    step;
    req_valid = 2'b00;
    chk("t2_btn", 8'(alu_btn), 8'b0001);
    step;
    rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", 8'(rsp_valid), 8'b10);
      chk("t2_hold_s", 8'(rsp_s), 8'd0);
      chk("t2_hold_flags", 8'(rsp_flags), 8'b011);
      step;
    end
    rsp_ready = 2'b10;
    step;
    rsp_ready = 2'b00;
    chk("t2_idle_valid", 8'(rsp_valid), 8'd0);

    // Req0 ADD 3+6.
    serve(0, 4'd3, 4'd6, 4'd1, 4'b0001, 4'd9, 3'b000);

    // Reset restores last_grant=1 so req0 wins the first contention.
    rst = 1'b1;
    step;
    rst = 1'b0;
    req0_a = 4'd3; req0_b = 4'd10; req0_op = 4'd2;
    req1_a = 4'd6; req1_b = 4'd2;  req1_op = 4'd4;
    req_valid = 2'b11;
    #1;
    chk("t3_grant0", 8'(req_ready), 8'b01);
    step;
    chk("t3_exec_noready", 8'(req_ready), 8'd0);
    chk("t3_exec_btn", 8'(alu_btn), 8'b0010);
    step;
    chk("t3_rsp0_valid", 8'(rsp_valid), 8'b01);
    chk("t3_rsp0_s", 8'(rsp_s), 8'd7);
    chk("t3_rsp0_flags", 8'(rsp_flags), 8'b000);
    chk("t3_resp_noready", 8'(req_ready), 8'd0);
    rsp_ready = 2'b01;
    step;
    rsp_ready = 2'b00;
    chk("t3_grant1", 8'(req_ready), 8'b10);
    step;
    chk("t3_exec1_btn", 8'(alu_btn), 8'b0100);
    chk("t3_exec1_a", 8'(alu_a), 8'd6);
    step;
    chk("t3_rsp1_valid", 8'(rsp_valid), 8'b10);
    chk("t3_rsp1_s", 8'(rsp_s), 8'd3);
    chk("t3_rsp1_flags", 8'(rsp_flags), 8'b000);
    rsp_ready = 2'b10;
    step;
    rsp_ready = 2'b00;
    chk("t3_grant0_again", 8'(req_ready), 8'b01);
    req_valid = 2'b00;
    step;

    // Error cases and a spread of legal ops.
    serve(0, 4'd3, 4'd0, 4'd5, 4'b0000, 4'd0, 3'b100);
    serve(0, 4'd1, 4'd2, 4'd12, 4'b0000, 4'd0, 3'b100);
    serve(1, 4'd7, 4'd0, 4'd4, 4'b0000, 4'd0, 3'b100);
    serve(1, 4'd3, 4'd5, 4'd3, 4'b0011, 4'd15, 3'b000);
    serve(0, 4'd12, 4'd10, 4'd6, 4'b0110, 4'd8, 3'b000);
    serve(1, 4'd12, 4'd3, 4'd7, 4'b0111, 4'd15, 3'b000);
    serve(0, 4'd5, 4'd5, 4'd2, 4'b0010, 4'd0, 3'b001);

    // Three-cycle settle window on the second instance.
    req0_a3 = 4'd5; req0_b3 = 4'd10; req0_op3 = 4'd8;
    req_valid3 = 2'b01;
    #1;
    chk("t5_ready", 8'(req_ready3), 8'b01);
    step;
    req_valid3 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("t5_exec_btn", 8'(alu_btn3), 8'b1000);
      chk("t5_exec_novalid", 8'(rsp_valid3), 8'd0);
      step;
    end
    chk("t5_rsp_valid", 8'(rsp_valid3), 8'b01);
    chk("t5_rsp_s", 8'(rsp_s3), 8'd15);
    chk("t5_rsp_flags", 8'(rsp_flags3), 8'b000);
    chk("t5_rsp_btn", 8'(alu_btn3), 8'd0);
    rsp_ready3 = 2'b01;
    step;
    rsp_ready3 = 2'b00;
    chk("t5_done", 8'(rsp_valid3), 8'd0);

    // Reset during EXEC drops the transaction.
    serve(0, 4'd3, 4'd6, 4'd1, 4'b0001, 4'd9, 3'b000);
    req0_a = 4'd12; req0_b = 4'd10; req0_op = 4'd6;
    req_valid = 2'b01;
    step;
    req_valid = 2'b00;
    chk("t6_exec_btn", 8'(alu_btn), 8'b0110);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("t6_rst_valid", 8'(rsp_valid), 8'd0);
    chk("t6_rst_btn", 8'(alu_btn), 8'd0);
    chk("t6_rst_s", 8'(rsp_s), 8'd0);
    chk("t6_rst_flags", 8'(rsp_flags), 8'd0);
    chk("t6_rst_a", 8'(alu_a), 8'd0);
    chk("t6_rst_ready", 8'(req_ready), 8'd0);
    step;
    chk("t6_no_late_rsp", 8'(rsp_valid), 8'd0);
    serve(0, 4'd3, 4'd6, 4'd1, 4'b0001, 4'd9, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
